// File: rtl/fifo_pkg.sv
// Shared types and helpers for the programmable synchronous FIFO.
package fifo_pkg;

  typedef enum logic {
    FIFO_REG,
    FIFO_FWFT
  } fifo_mode_e;

  // Width able to hold every occupancy value 0..depth inclusive.
  function automatic int fifo_lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Pointer counter that wraps from DEPTH-1 back to 0, so DEPTH need not be a power of two.
module fifo_ptr_wrap #(
  parameter int DEPTH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;

  always_comb begin
    ptr_next = ptr_reg;
    if (inc) begin
      ptr_next = (ptr_reg == LAST) ? '0 : ptr_reg + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with arbitrary depth, registered or fall-through read, and programmable thresholds.
// Sticky overflow/underflow flags are built only when FIFO_SYNC_PROG_ERR_FLAGS_EN is defined.
module fifo_sync_prog
  import fifo_pkg::*;
#(
  parameter int         DATA_W    = 8,
  parameter int         DEPTH     = 6,
  parameter fifo_mode_e MODE      = FIFO_REG,
  parameter int         AF_THRESH = DEPTH - 1,
  parameter int         AE_THRESH = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             data_in,
  output logic                          full,
  output logic                          almost_full,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             data_out,
  output logic                          rd_valid,
  output logic                          empty,
  output logic                          almost_empty,
  output logic [fifo_lvl_w(DEPTH)-1:0]  level,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          err_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = fifo_lvl_w(DEPTH);

  if (DATA_W < 1 || DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
      AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_param
    $fatal(1, "fifo_sync_prog: DATA_W/DEPTH/threshold parameter out of range");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_reg;
  logic [LVL_W-1:0]  level_next;
  logic              wr_acc;
  logic              rd_acc;

  // Acceptance looks only at the registered level, so a same-cycle pop never frees a slot for a push.
  assign wr_acc = wr_en && !full  && !rst;
  assign rd_acc = rd_en && !empty && !rst;

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_acc),
    .ptr (wr_ptr)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_acc),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_comb begin
    level_next = level_reg;
    case ({wr_acc, rd_acc})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg <= '0;
    end else begin
      level_reg <= level_next;
    end
  end

  assign level        = level_reg;
  assign full         = (level_reg == LVL_W'(DEPTH));
  assign empty        = (level_reg == '0);
  assign almost_full  = (level_reg >= LVL_W'(AF_THRESH));
  assign almost_empty = (level_reg <= LVL_W'(AE_THRESH));

  if (MODE == FIFO_REG) begin : g_reg_read
    logic [DATA_W-1:0] data_out_reg;
    logic              rd_valid_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        data_out_reg <= '0;
        rd_valid_reg <= 1'b0;
      end else begin
        rd_valid_reg <= rd_acc;
        if (rd_acc) begin
          data_out_reg <= mem[rd_ptr];
        end
      end
    end

    assign data_out = data_out_reg;
    assign rd_valid = rd_valid_reg;
  end else begin : g_fwft_read
    // Masked while empty so the output is a defined zero instead of stale or uninitialised memory.
    assign data_out = empty ? '0 : mem[rd_ptr];
    assign rd_valid = !empty;
  end

`ifdef FIFO_SYNC_PROG_ERR_FLAGS_EN
  logic overflow_reg;
  logic underflow_reg;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow_reg <= 1'b1;
      end else if (err_clr) begin
        overflow_reg <= 1'b0;
      end
      if (rd_en && empty) begin
        underflow_reg <= 1'b1;
      end else if (err_clr) begin
        underflow_reg <= 1'b0;
      end
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Directed bench for fifo_sync_prog: a registered-read and a fall-through instance share one stimulus stream.
module tb_fifo_sync_prog;
  import fifo_pkg::*;

`ifdef FIFO_SYNC_PROG_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] data_in = '0;

  logic       r_full, r_af, r_empty, r_ae, r_valid, r_ovf, r_unf;
  logic [7:0] r_data;
  logic [2:0] r_level;
  logic       f_full, f_af, f_empty, f_ae, f_valid, f_ovf, f_unf;
  logic [7:0] f_data;
  logic [2:0] f_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_sync_prog #(.DATA_W(8), .DEPTH(6), .MODE(FIFO_REG)) u_reg (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in),
    .full(r_full), .almost_full(r_af), .rd_en(rd_en), .data_out(r_data),
    .rd_valid(r_valid), .empty(r_empty), .almost_empty(r_ae), .level(r_level),
    .overflow(r_ovf), .underflow(r_unf), .err_clr(err_clr)
  );

  fifo_sync_prog #(.DATA_W(8), .DEPTH(6), .MODE(FIFO_FWFT)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in),
    .full(f_full), .almost_full(f_af), .rd_en(rd_en), .data_out(f_data),
    .rd_valid(f_valid), .empty(f_empty), .almost_empty(f_ae), .level(f_level),
    .overflow(f_ovf), .underflow(f_unf), .err_clr(err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    $display("txn t=%0t rst=%0b wr=%0b din=%02h rd=%0b clr=%0b -> level=%0d reg_dout=%02h reg_vld=%0b fwft_dout=%02h fwft_vld=%0b",
             $time, rst, wr_en, data_in, rd_en, err_clr, r_level, r_data, r_valid, f_data, f_valid);
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (r_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", r_level); end
    checks++; if ({r_empty, r_ae, r_full, r_af} !== 4'b1100) begin errors++; $display("FAIL reset_flags: got %b want 1100", {r_empty, r_ae, r_full, r_af}); end
    checks++; if ({r_valid, r_data} !== 9'h000) begin errors++; $display("FAIL reset_dout: got vld=%0b data=%02h want 0/00", r_valid, r_data); end
    checks++; if ({f_valid, f_data} !== 9'h000) begin errors++; $display("FAIL reset_fwft_dout: got vld=%0b data=%02h want 0/00", f_valid, f_data); end
    checks++; if ({r_ovf, r_unf} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", {r_ovf, r_unf}); end
  endtask

  task automatic test_fill_drain();
    idle();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; data_in = 8'h11 + 8'(i); tick();
      checks++; if (r_level !== 3'(i + 1)) begin errors++; $display("FAIL fill_level: got %0d want %0d", r_level, i + 1); end
      checks++; if (r_full !== (i == 5)) begin errors++; $display("FAIL fill_full: got %0b want %0b at level %0d", r_full, (i == 5), i + 1); end
      checks++; if (r_af !== (i >= 4)) begin errors++; $display("FAIL fill_almost_full: got %0b want %0b at level %0d", r_af, (i >= 4), i + 1); end
    end
    data_in = 8'h77; tick();
    checks++; if (r_level !== 3'd6) begin errors++; $display("FAIL overfill_level: got %0d want 6", r_level); end
    checks++; if (r_ovf !== ERR_EN) begin errors++; $display("FAIL overfill_overflow: got %0b want %0b", r_ovf, ERR_EN); end
    idle(); err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++; if (r_ovf !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %0b want 0", r_ovf); end
    for (int i = 0; i < 6; i++) begin
      rd_en = 1'b0;
      checks++; if (f_data !== 8'h11 + 8'(i)) begin errors++; $display("FAIL drain_fwft_head: got %02h want %02h", f_data, 8'h11 + 8'(i)); end
      rd_en = 1'b1; tick();
      checks++; if (r_data !== 8'h11 + 8'(i) || r_valid !== 1'b1) begin errors++; $display("FAIL drain_data: got %02h vld=%0b want %02h vld=1", r_data, r_valid, 8'h11 + 8'(i)); end
      checks++; if (r_level !== 3'(5 - i)) begin errors++; $display("FAIL drain_level: got %0d want %0d", r_level, 5 - i); end
    end
    idle();
    checks++; if ({r_empty, r_ae} !== 2'b11) begin errors++; $display("FAIL drain_empty: got %b want 11", {r_empty, r_ae}); end
    tick();
    checks++; if (r_valid !== 1'b0 || r_data !== 8'h16) begin errors++; $display("FAIL drain_hold: got vld=%0b data=%02h want 0/16", r_valid, r_data); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_rd;
    exp_rd = 8'h00;
    idle();
    wr_en = 1'b1; data_in = 8'h00; tick();
    data_in = 8'h01; tick();
    for (int k = 2; k < 20; k++) begin
      wr_en = 1'b1; rd_en = 1'b0; data_in = 8'(k); tick();
      checks++; if (r_level !== 3'd3) begin errors++; $display("FAIL wrap_level_up: got %0d want 3", r_level); end
      wr_en = 1'b0;
      checks++; if (f_data !== exp_rd) begin errors++; $display("FAIL wrap_fwft_head: got %02h want %02h", f_data, exp_rd); end
      rd_en = 1'b1; tick();
      checks++; if (r_data !== exp_rd || r_valid !== 1'b1) begin errors++; $display("FAIL wrap_data: got %02h vld=%0b want %02h", r_data, r_valid, exp_rd); end
      checks++; if (r_level !== 3'd2) begin errors++; $display("FAIL wrap_level_down: got %0d want 2", r_level); end
      exp_rd++;
    end
    for (int k = 0; k < 2; k++) begin
      wr_en = 1'b0; rd_en = 1'b1; tick();
      checks++; if (r_data !== exp_rd) begin errors++; $display("FAIL wrap_tail: got %02h want %02h", r_data, exp_rd); end
      exp_rd++;
    end
    idle();
    checks++; if (r_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %0b want 1", r_empty); end
  endtask

  task automatic test_simultaneous();
    idle();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; data_in = 8'hA1 + 8'(i); tick();
    end
    rd_en = 1'b1; data_in = 8'hA4; tick();
    checks++; if (r_level !== 3'd3) begin errors++; $display("FAIL both_mid_level: got %0d want 3", r_level); end
    checks++; if (r_data !== 8'hA1 || r_valid !== 1'b1) begin errors++; $display("FAIL both_mid_data: got %02h vld=%0b want a1", r_data, r_valid); end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (r_data !== 8'hA2 + 8'(i)) begin errors++; $display("FAIL both_mid_drain: got %02h want %02h", r_data, 8'hA2 + 8'(i)); end
    end
    wr_en = 1'b1; rd_en = 1'b1; data_in = 8'hB0; tick();
    checks++; if (r_level !== 3'd1 || r_valid !== 1'b0) begin errors++; $display("FAIL both_empty: got level=%0d vld=%0b want 1/0", r_level, r_valid); end
    checks++; if (r_unf !== ERR_EN) begin errors++; $display("FAIL both_empty_underflow: got %0b want %0b", r_unf, ERR_EN); end
    idle(); err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++; if (r_unf !== 1'b0) begin errors++; $display("FAIL underflow_clear: got %0b want 0", r_unf); end
    for (int i = 1; i < 6; i++) begin
      wr_en = 1'b1; data_in = 8'hB0 + 8'(i); tick();
    end
    checks++; if (r_level !== 3'd6 || r_full !== 1'b1) begin errors++; $display("FAIL both_prefill: got level=%0d full=%0b want 6/1", r_level, r_full); end
    rd_en = 1'b1; data_in = 8'hCC; tick();
    checks++; if (r_level !== 3'd5 || r_data !== 8'hB0) begin errors++; $display("FAIL both_full: got level=%0d data=%02h want 5/b0", r_level, r_data); end
    checks++; if (r_ovf !== ERR_EN) begin errors++; $display("FAIL both_full_overflow: got %0b want %0b", r_ovf, ERR_EN); end
    idle(); err_clr = 1'b1; tick(); err_clr = 1'b0;
    rd_en = 1'b1;
    for (int i = 1; i < 6; i++) begin
      tick();
      checks++; if (r_data !== 8'hB0 + 8'(i)) begin errors++; $display("FAIL both_full_drain: got %02h want %02h", r_data, 8'hB0 + 8'(i)); end
    end
    idle();
    checks++; if (r_empty !== 1'b1) begin errors++; $display("FAIL both_full_dropped: got empty=%0b want 1", r_empty); end
  endtask

  task automatic test_fwft();
    idle();
    wr_en = 1'b1; data_in = 8'hA5; tick(); wr_en = 1'b0;
    checks++; if ({f_empty, f_valid} !== 2'b01 || f_data !== 8'hA5) begin errors++; $display("FAIL fwft_show: got empty=%0b vld=%0b data=%02h want 0/1/a5", f_empty, f_valid, f_data); end
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL fwft_reg_quiet: got %0b want 0", r_valid); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    checks++; if ({f_empty, f_valid} !== 2'b10) begin errors++; $display("FAIL fwft_pop: got empty=%0b vld=%0b want 1/0", f_empty, f_valid); end
    checks++; if (r_data !== 8'hA5 || r_valid !== 1'b1) begin errors++; $display("FAIL fwft_reg_read: got %02h vld=%0b want a5/1", r_data, r_valid); end
  endtask

  task automatic test_reset_mid();
    idle();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; data_in = 8'hC0 + 8'(i); tick();
    end
    checks++; if (r_level !== 3'd4) begin errors++; $display("FAIL rstmid_prefill: got %0d want 4", r_level); end
    rd_en = 1'b1; tick();
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b0; data_in = 8'hEE; tick();
    rst = 1'b0; wr_en = 1'b0;
    checks++; if (r_level !== 3'd0 || r_empty !== 1'b1) begin errors++; $display("FAIL rstmid_level: got level=%0d empty=%0b want 0/1", r_level, r_empty); end
    checks++; if (r_valid !== 1'b0 || r_data !== 8'h00) begin errors++; $display("FAIL rstmid_dout: got vld=%0b data=%02h want 0/00", r_valid, r_data); end
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL rstmid_fwft_vld: got %0b want 0", f_valid); end
    tick();
    checks++; if (r_level !== 3'd0) begin errors++; $display("FAIL rstmid_write_ignored: got %0d want 0", r_level); end
  endtask

  task automatic test_err_flags();
    idle();
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    checks++; if (r_unf !== ERR_EN) begin errors++; $display("FAIL err_set: got %0b want %0b", r_unf, ERR_EN); end
    tick();
    checks++; if (r_unf !== ERR_EN) begin errors++; $display("FAIL err_sticky: got %0b want %0b", r_unf, ERR_EN); end
    rd_en = 1'b1; err_clr = 1'b1; tick(); rd_en = 1'b0;
    checks++; if (r_unf !== ERR_EN) begin errors++; $display("FAIL err_set_wins: got %0b want %0b", r_unf, ERR_EN); end
    tick(); err_clr = 1'b0;
    checks++; if (r_unf !== 1'b0 || r_ovf !== 1'b0) begin errors++; $display("FAIL err_clear: got unf=%0b ovf=%0b want 0/0", r_unf, r_ovf); end
    checks++; if (f_unf !== 1'b0) begin errors++; $display("FAIL err_clear_fwft: got %0b want 0", f_unf); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_fwft();
    test_reset_mid();
    test_err_flags();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
